mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single external memory port between the instruction-cache refill path (fetch-stage miss, 4-word line burst) and the memory-stage data path (single-word load/store). A three-state controller grants one requester at a time, sequences the transfer beats, and raises `busy` so the hazard logic can stall the pipeline. Grants are round-robin under contention, and a started transaction is never preempted.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `LINE_WORDS`, 4, words per I-line refill; power of two, at least 2
- `clk` input 1: the only clock; rising edge
- `rst` input 1: asynchronous, active-low reset
- `i_req` input 1: I-refill request, level; held until `i_done`
- `i_addr` input ADDR_W: refill address; low log2(LINE_WORDS)+2 bits ignored
- `i_rdata` output DATA_W: refill beat data
- `i_rvalid` output 1: `i_rdata` valid this cycle
- `i_beat` output log2(LINE_WORDS): word index of the current beat
- `i_done` output 1: pulse with the last beat
- `d_req` input 1: data request, level; held until `d_done`
- `d_we` input 1: 1 = store, 0 = load
- `d_addr` input ADDR_W: word address
- `d_wdata` input DATA_W: store data
- `d_rdata` output DATA_W: load data, valid with `d_done`
- `d_done` output 1: pulse on completion
- `mem_req` output 1: transfer request to memory
- `mem_we` output 1: write strobe
- `mem_addr` output ADDR_W: transfer address
- `mem_wdata` output DATA_W: write data
- `mem_rdata` input DATA_W: read data, valid with `mem_ack`
- `mem_ack` input 1: one pulse per completed transfer
- `busy` output 1: state is not IDLE

## Operation
- States: IDLE, I_BURST, D_ACCESS.
- In IDLE:
  - If only `i_req` is high, go to I_BURST. If only `d_req` is high, go to D_ACCESS.
  - If both are high, grant the side not recorded in `last_grant`, then update `last_grant`.
  - `last_grant` resets to D, so the first tie goes to I.
- In I_BURST:
  - `mem_req`=1, `mem_we`=0, `mem_addr` = line base + (beat << 2).
  - On `mem_ack`: `i_rvalid`=1, `i_rdata`=`mem_rdata`, `i_beat`=beat, then beat increments.
  - On the ack of beat LINE_WORDS-1: `i_done`=1, beat clears to 0, next state IDLE.
- In D_ACCESS:
  - `mem_req`=1, `mem_we`=`d_we`, `mem_addr`=`d_addr`, `mem_wdata`=`d_wdata`.
  - On `mem_ack`: `d_done`=1, `d_rdata`=`mem_rdata`, next state IDLE.
- `mem_addr`, `mem_we` and `mem_wdata` are held stable between acks. `mem_ack` seen in IDLE is ignored.
- A requester must drop its req at the clock edge where its done is high. A req still high in the following IDLE cycle is treated as a new request.
- The beat address wraps only within the line; there is no carry into the line base.

## Timing
- State, beat counter and `last_grant` are registered. Everything else on the `mem_*`, `i_*` and `d_*` outputs is decoded combinationally from state and inputs, with `mem_rdata` passed straight through.
- Request to `mem_req`: 1 cycle (one IDLE cycle).
- Beat completes in the same cycle as `mem_ack`; zero added latency.
- Between transactions `mem_req` is low for at least one IDLE cycle.
- Best-case I-refill: 1 + LINE_WORDS cycles with `mem_ack` tied high. Best-case D access: 2 cycles.
- Reset (`rst`=0), at any time including mid-burst:
  - Immediately: state=IDLE, beat=0, `last_grant`=D.
  - All outputs 0: `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `i_rvalid`, `i_done`, `d_done`, `busy`, `i_rdata`, `d_rdata`, `i_beat`.
  - An interrupted transaction is abandoned; the requester re-requests after reset.
- A `d_req` arriving during I_BURST waits for the whole burst; the pipeline stalls on `busy`.

## Structure
- Shared package `mem_arb_pkg`:
  - state typedef (IDLE, I_BURST, D_ACCESS) and grant typedef (GRANT_I, GRANT_D);
  - `LINE_WORDS` default and derived `BEAT_W`.
- Sub-module `line_beat_counter`: beat counter with increment, clear and `last` flag, parameterised by `LINE_WORDS`.
- The top level holds the FSM, `last_grant` and the output muxing.

## Test plan
- `i_req`=1, `i_addr`=0x0000_1008, `mem_ack` always 1:
  - `mem_addr` 0x1000, 0x1004, 0x1008, 0x100C on cycles 1–4;
  - `i_beat` 0–3; `i_done` on cycle 4; `busy` low on cycle 5.
- Store with `d_addr`=0x2000, `d_wdata`=0xDEADBEEF, `mem_ack` delayed 3 cycles:
  - `mem_we`=1 and address/data held stable for 3 cycles;
  - `d_done` in the ack cycle; no `i_*` activity.
- `i_req` and `d_req` both asserted after reset:
  - I burst is granted first, then D after one IDLE cycle.
  - Repeating the simultaneous request grants D first.
- `d_req` raised during beat 1 of an I burst:
  - the burst completes all 4 beats; D is granted in the IDLE cycle after `i_done`; `d_rdata` = memory value.
- `rst` pulled low during beat 2:
  - `mem_req` drops without a clock edge and all outputs read 0.
  - After release, a new `i_req` restarts at beat 0 with `mem_addr` = line base.
- Stray `mem_ack` while IDLE: no done or valid pulse, state unchanged.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter.
// Controller states, grant encoding and line geometry defaults.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      I_BURST  = 2'd1,
      D_ACCESS = 2'd2
   } arbState_t;

   typedef enum logic {
      GRANT_I = 1'b0,
      GRANT_D = 1'b1
   } grant_t;

   // Counter width for a line, never narrower than one bit.
   function automatic int beatWidth(input int words);
      return (words < 2) ? 1 : $clog2(words);
   endfunction

   localparam int LINE_WORDS_DEF = 4;
   localparam int BEAT_W_DEF = beatWidth(LINE_WORDS_DEF);

endpackage

// File: rtl/line_beat_counter.sv
// Word index within an I-line refill burst.
// Steps on each acked beat; flags the final word of the line.
module line_beat_counter #(
   parameter int LINE_WORDS = 4,
   parameter int BEAT_W = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              inc,
   input  logic              clr,
   output logic [BEAT_W-1:0] beat,
   output logic              last
);

   localparam logic [BEAT_W-1:0] LAST_BEAT =
      BEAT_W'(LINE_WORDS - 1);

   // Advance one word per acked beat; clear wins
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         beat <= '0;
      end else if (clr) begin
         beat <= '0;
      end else if (inc) begin
         beat <= beat + 1'b1;
      end
   end

   // Final word of the line is being transferred
   always_comb begin
      last = (beat == LAST_BEAT);
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between I-refill and D access.
// Round-robin on ties, no preemption, outputs decoded from state.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int LINE_WORDS = LINE_WORDS_DEF,
   localparam int BEAT_W = beatWidth(LINE_WORDS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_rvalid,
   output logic [BEAT_W-1:0] i_beat,
   output logic              i_done,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_done,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              busy
);

   localparam int OFF_W = BEAT_W + 2;

   arbState_t         state;
   grant_t            lastGrant;
   logic [BEAT_W-1:0] beat;
   logic              beatLast;
   logic              inBurst;
   logic              inData;
   logic              iAck;
   logic              dAck;
   logic              tie;
   logic              clrBeat;
   logic [ADDR_W-1:0] beatAddr;
   logic              unusedAddrBits;

   // Which requester currently owns the port
   always_comb begin
      inBurst = (state == I_BURST);
      inData  = (state == D_ACCESS);
      iAck    = inBurst & mem_ack;
      dAck    = inData & mem_ack;
      tie     = i_req & d_req;
      clrBeat = ~inBurst | (iAck & beatLast);
   end

   // Line base keeps its upper bits; beat wraps inside the line
   always_comb begin
      beatAddr = {i_addr[ADDR_W-1:OFF_W], beat, 2'b00};
   end

   assign unusedAddrBits = ^i_addr[OFF_W-1:0];

   line_beat_counter #(
      .LINE_WORDS(LINE_WORDS),
      .BEAT_W    (BEAT_W)
   ) u_beat (
      .clk (clk),
      .rst (rst),
      .inc (iAck),
      .clr (clrBeat),
      .beat(beat),
      .last(beatLast)
   );

   // Grant from IDLE, hold until the final ack; ties alternate
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         lastGrant <= GRANT_D;
      end else begin
         unique case (state)
            IDLE: begin
               if (tie) begin
                  if (lastGrant == GRANT_D) begin
                     state     <= I_BURST;
                     lastGrant <= GRANT_I;
                  end else begin
                     state     <= D_ACCESS;
                     lastGrant <= GRANT_D;
                  end
               end else if (i_req) begin
                  state <= I_BURST;
               end else if (d_req) begin
                  state <= D_ACCESS;
               end
            end
            I_BURST: begin
               if (iAck && beatLast) begin
                  state <= IDLE;
               end
            end
            D_ACCESS: begin
               if (mem_ack) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Route the owning requester onto the memory port
   always_comb begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      unique case (1'b1)
         inBurst: begin
            mem_req  = 1'b1;
            mem_addr = beatAddr;
         end
         inData: begin
            mem_req   = 1'b1;
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
         end
         default: begin
         end
      endcase
   end

   // Return read data and completion pulses to the owner
   always_comb begin
      i_rvalid = iAck;
      i_rdata  = iAck ? mem_rdata : '0;
      i_beat   = inBurst ? beat : '0;
      i_done   = iAck & beatLast;
      d_done   = dAck;
      d_rdata  = dAck ? mem_rdata : '0;
      busy     = (state != IDLE);
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter.
// Transaction-level model compared every cycle plus literal checks.
module tb_mem_port_arbiter;

   localparam int LW = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_req;
   logic [31:0] i_addr;
   logic [31:0] i_rdata;
   logic        i_rvalid;
   logic [1:0]  i_beat;
   logic        i_done;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [31:0] d_rdata;
   logic        d_done;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic        busy;

   int nChecks = 0;
   int nFails = 0;

   mem_port_arbiter dut (
      .clk      (clk),
      .rst      (rst),
      .i_req    (i_req),
      .i_addr   (i_addr),
      .i_rdata  (i_rdata),
      .i_rvalid (i_rvalid),
      .i_beat   (i_beat),
      .i_done   (i_done),
      .d_req    (d_req),
      .d_we     (d_we),
      .d_addr   (d_addr),
      .d_wdata  (d_wdata),
      .d_rdata  (d_rdata),
      .d_done   (d_done),
      .mem_req  (mem_req),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .mem_ack  (mem_ack),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("FAIL %s: got %h want %h at %0t",
                  name, act, exp, $time);
      end
   endtask

   // Model: who owns the port and how many line words remain
   int mdlOwner = 0;
   int mdlLeft = 0;
   bit mdlPreferI = 1'b1;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         mdlOwner   <= 0;
         mdlLeft    <= 0;
         mdlPreferI <= 1'b1;
      end else if (mdlOwner == 0) begin
         if (i_req && d_req) begin
            mdlOwner   <= mdlPreferI ? 1 : 2;
            mdlLeft    <= mdlPreferI ? LW : 0;
            mdlPreferI <= !mdlPreferI;
         end else if (i_req) begin
            mdlOwner <= 1;
            mdlLeft  <= LW;
         end else if (d_req) begin
            mdlOwner <= 2;
         end
      end else if (mem_ack) begin
         if (mdlOwner == 2 || mdlLeft == 1) begin
            mdlOwner <= 0;
            mdlLeft  <= 0;
         end else begin
            mdlLeft <= mdlLeft - 1;
         end
      end
   end

   // Compare every output against the model mid-cycle
   always @(negedge clk) begin
      logic        ownI;
      logic        ownD;
      int          idx;
      logic [31:0] eAddr;
      ownI = (mdlOwner == 1);
      ownD = (mdlOwner == 2);
      idx = ownI ? (LW - mdlLeft) : 0;
      eAddr = ownI ? ((i_addr & ~32'(LW * 4 - 1)) + 32'(idx * 4))
            : ownD ? d_addr : 32'd0;
      chk("cmpBusy", 32'(busy), 32'(ownI | ownD));
      chk("cmpMemReq", 32'(mem_req), 32'(ownI | ownD));
      chk("cmpMemWe", 32'(mem_we), 32'(ownD & d_we));
      chk("cmpMemAddr", mem_addr, eAddr);
      chk("cmpMemWdata", mem_wdata, ownD ? d_wdata : 32'd0);
      chk("cmpIValid", 32'(i_rvalid), 32'(ownI & mem_ack));
      chk("cmpIRdata", i_rdata,
          (ownI & mem_ack) ? mem_rdata : 32'd0);
      chk("cmpIBeat", 32'(i_beat), 32'(idx));
      chk("cmpIDone", 32'(i_done),
          32'(ownI & mem_ack & (mdlLeft == 1)));
      chk("cmpDDone", 32'(d_done), 32'(ownD & mem_ack));
      chk("cmpDRdata", d_rdata,
          (ownD & mem_ack) ? mem_rdata : 32'd0);
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic look();
      #2;
   endtask

   initial begin
      rst = 1'b0;
      i_req = 1'b0;
      i_addr = '0;
      d_req = 1'b0;
      d_we = 1'b0;
      d_addr = '0;
      d_wdata = '0;
      mem_rdata = '0;
      mem_ack = 1'b0;
      repeat (2) cyc();
      chk("rstBusy", 32'(busy), 32'd0);
      chk("rstMemReq", 32'(mem_req), 32'd0);
      rst = 1'b1;

      // I refill, ack tied high
      cyc();
      i_req = 1'b1;
      i_addr = 32'h0000_1008;
      mem_ack = 1'b1;
      look();
      chk("t1IdleBusy", 32'(busy), 32'd0);
      for (int k = 0; k < 4; k++) begin
         cyc();
         mem_rdata = 32'hA000_0000 + 32'(k);
         look();
         chk("t1Addr", mem_addr, 32'h1000 + 32'(4 * k));
         chk("t1Beat", 32'(i_beat), 32'(k));
         chk("t1Done", 32'(i_done), 32'(k == 3));
         chk("t1Rdata", i_rdata, 32'hA000_0000 + 32'(k));
      end
      cyc();
      i_req = 1'b0;
      look();
      chk("t1Cycle5Busy", 32'(busy), 32'd0);
      chk("t1StrayValid", 32'(i_rvalid), 32'd0);
      mem_ack = 1'b0;

      // Store, ack after 3 wait cycles
      cyc();
      d_req = 1'b1;
      d_we = 1'b1;
      d_addr = 32'h2000;
      d_wdata = 32'hDEAD_BEEF;
      look();
      chk("t2IdleBusy", 32'(busy), 32'd0);
      for (int k = 0; k < 3; k++) begin
         cyc();
         look();
         chk("t2We", 32'(mem_we), 32'd1);
         chk("t2Addr", mem_addr, 32'h2000);
         chk("t2Wdata", mem_wdata, 32'hDEAD_BEEF);
         chk("t2NoDone", 32'(d_done), 32'd0);
         chk("t2NoI", 32'(i_rvalid), 32'd0);
      end
      cyc();
      mem_ack = 1'b1;
      look();
      chk("t2Done", 32'(d_done), 32'd1);
      cyc();
      d_req = 1'b0;
      d_we = 1'b0;
      mem_ack = 1'b0;
      look();
      chk("t2Idle", 32'(busy), 32'd0);

      // Tie after reset: I first, then D; next tie goes to D
      cyc();
      rst = 1'b0;
      cyc();
      rst = 1'b1;
      cyc();
      i_req = 1'b1;
      d_req = 1'b1;
      i_addr = 32'h3000;
      d_addr = 32'h3100;
      mem_ack = 1'b1;
      mem_rdata = 32'h33;
      look();
      chk("t3IdleBusy", 32'(busy), 32'd0);
      cyc();
      look();
      chk("t3FirstI", 32'(i_rvalid), 32'd1);
      chk("t3FirstAddr", mem_addr, 32'h3000);
      repeat (3) cyc();
      look();
      chk("t3IDone", 32'(i_done), 32'd1);
      cyc();
      i_req = 1'b0;
      look();
      chk("t3Gap", 32'(busy), 32'd0);
      cyc();
      look();
      chk("t3ThenD", 32'(d_done), 32'd1);
      chk("t3DAddr", mem_addr, 32'h3100);
      cyc();
      d_req = 1'b0;
      look();
      chk("t3Idle", 32'(busy), 32'd0);
      cyc();
      i_req = 1'b1;
      d_req = 1'b1;
      look();
      chk("t3Idle2", 32'(busy), 32'd0);
      cyc();
      look();
      chk("t3SecondD", 32'(d_done), 32'd1);
      chk("t3SecondNoI", 32'(i_rvalid), 32'd0);
      cyc();
      d_req = 1'b0;
      look();
      chk("t3Gap2", 32'(busy), 32'd0);
      cyc();
      look();
      chk("t3LaterI", 32'(i_rvalid), 32'd1);
      chk("t3LaterBeat", 32'(i_beat), 32'd0);
      repeat (3) cyc();
      cyc();
      i_req = 1'b0;
      look();
      chk("t3End", 32'(busy), 32'd0);

      // D request raised during beat 1 waits for the burst
      cyc();
      i_req = 1'b1;
      i_addr = 32'h4010;
      look();
      cyc();
      cyc();
      d_req = 1'b1;
      d_we = 1'b0;
      d_addr = 32'h5004;
      look();
      chk("t4Beat1", 32'(i_beat), 32'd1);
      cyc();
      look();
      chk("t4Beat2", 32'(i_beat), 32'd2);
      chk("t4Addr2", mem_addr, 32'h4018);
      chk("t4NoD", 32'(d_done), 32'd0);
      cyc();
      look();
      chk("t4IDone", 32'(i_done), 32'd1);
      chk("t4Beat3", 32'(i_beat), 32'd3);
      cyc();
      i_req = 1'b0;
      look();
      chk("t4Gap", 32'(busy), 32'd0);
      cyc();
      mem_rdata = 32'hCAFE_F00D;
      look();
      chk("t4DDone", 32'(d_done), 32'd1);
      chk("t4DRdata", d_rdata, 32'hCAFE_F00D);
      chk("t4DAddr", mem_addr, 32'h5004);
      cyc();
      d_req = 1'b0;
      look();
      chk("t4Idle", 32'(busy), 32'd0);

      // Reset during beat 2 abandons the burst
      cyc();
      i_req = 1'b1;
      i_addr = 32'h6008;
      look();
      cyc();
      cyc();
      cyc();
      mem_ack = 1'b0;
      look();
      chk("t5Beat2", 32'(i_beat), 32'd2);
      chk("t5Busy", 32'(busy), 32'd1);
      chk("t5Addr", mem_addr, 32'h6008);
      mem_ack = 1'b1;
      rst = 1'b0;
      #1;
      chk("t5RstReq", 32'(mem_req), 32'd0);
      chk("t5RstBusy", 32'(busy), 32'd0);
      chk("t5RstAddr", mem_addr, 32'd0);
      chk("t5RstBeat", 32'(i_beat), 32'd0);
      chk("t5RstValid", 32'(i_rvalid), 32'd0);
      chk("t5RstRdata", i_rdata, 32'd0);
      i_req = 1'b0;
      mem_ack = 1'b0;
      cyc();
      rst = 1'b1;
      cyc();
      i_req = 1'b1;
      mem_ack = 1'b1;
      look();
      chk("t5ReIdle", 32'(busy), 32'd0);
      cyc();
      look();
      chk("t5ReBeat", 32'(i_beat), 32'd0);
      chk("t5ReAddr", mem_addr, 32'h6000);
      chk("t5ReValid", 32'(i_rvalid), 32'd1);
      repeat (3) cyc();
      cyc();
      i_req = 1'b0;
      look();
      chk("t5End", 32'(busy), 32'd0);

      // Stray ack in IDLE
      mem_ack = 1'b0;
      cyc();
      mem_ack = 1'b1;
      mem_rdata = 32'h77;
      look();
      chk("t6NoValid", 32'(i_rvalid), 32'd0);
      chk("t6NoDDone", 32'(d_done), 32'd0);
      chk("t6NoIRdata", i_rdata, 32'd0);
      chk("t6NoDRdata", d_rdata, 32'd0);
      cyc();
      look();
      chk("t6StillIdle", 32'(busy), 32'd0);
      cyc();
      mem_ack = 1'b0;
      repeat (2) cyc();

      $display("End of test - %0d assertions evaluated, %0d failures",
               nChecks, nFails);
      $finish;
   end

endmodule
